// File: rtl/qeciphy_rx_checker_pkg.sv
// Shared types and default parameters for the QECIPHY receive-side checker.
package qeciphy_rx_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_chk_state_t;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_CNT_WIDTH      = 32;
    localparam int DEF_LOCK_THRESHOLD = 16;
    localparam int DEF_LOSS_THRESHOLD = 8;

    // Bits needed to hold any run length up to the larger of the two thresholds.
    function automatic int run_cnt_width(input int lock_thr, input int loss_thr);
        int max_thr;
        max_thr = (lock_thr > loss_thr) ? lock_thr : loss_thr;
        return $clog2(max_thr + 1);
    endfunction

endpackage

// File: rtl/qeciphy_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment leaves the count at 1 so the concurrent event is not lost.
module qeciphy_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARST,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            count <= '0;
        end else if (clear) begin
            count <= increment ? ONE : '0;
        end else if (increment && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/qeciphy_rx_checker.sv
// Incrementing-counter payload checker for the QECIPHY RX AXI-Stream.
// Acquires lock on the sequence, counts verified words and mismatches while
// locked, and falls back to hunting after a run of consecutive mismatches.
//
// state  | meaning
// HUNT   | no reference; the next beat seeds the expected value
// VERIFY | counting consecutive matches towards lock; mismatches re-seed
// LOCKED | free-running reference; words and errors are counted
module qeciphy_rx_checker #(
    parameter int DATA_WIDTH     = qeciphy_rx_checker_pkg::DEF_DATA_WIDTH,
    parameter int CNT_WIDTH      = qeciphy_rx_checker_pkg::DEF_CNT_WIDTH,
    parameter int LOCK_THRESHOLD = qeciphy_rx_checker_pkg::DEF_LOCK_THRESHOLD,
    parameter int LOSS_THRESHOLD = qeciphy_rx_checker_pkg::DEF_LOSS_THRESHOLD
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic [DATA_WIDTH-1:0] RX_TDATA,
    input  logic                  RX_TVALID,
    output logic                  RX_TREADY,
    input  logic                  CLEAR,
    output logic                  LOCKED,
    output logic                  ERROR,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    output logic [CNT_WIDTH-1:0]  WORD_COUNT
);

    // The port LOCKED shadows the enum literal of the same name, so the
    // locked state is always referenced through the package scope.
    import qeciphy_rx_checker_pkg::*;

    localparam int RUN_W = run_cnt_width(LOCK_THRESHOLD, LOSS_THRESHOLD);

    // Run value held just before the beat that completes lock / loss.
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_THRESHOLD - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_THRESHOLD - 1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    rx_chk_state_t         state;
    logic [DATA_WIDTH-1:0] expected;
    logic [RUN_W-1:0]      run_cnt;

    logic beat;
    logic match;
    logic word_inc;
    logic err_inc;

    assign beat     = RX_TVALID & RX_TREADY;
    assign match    = (RX_TDATA == expected);
    assign word_inc = beat & (state == qeciphy_rx_checker_pkg::LOCKED);
    assign err_inc  = word_inc & ~match;

    // Ready comes up on the first edge out of reset and then stays high.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            RX_TREADY <= 1'b0;
        end else begin
            RX_TREADY <= 1'b1;
        end
    end

    // Lock acquisition / loss FSM with the reference value and run counter.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state    <= HUNT;
            expected <= '0;
            run_cnt  <= '0;
            LOCKED   <= 1'b0;
        end else if (beat) begin
            case (state)
                HUNT: begin
                    expected <= RX_TDATA + DATA_ONE;
                    run_cnt  <= RUN_ONE;
                    state    <= VERIFY;
                end
                VERIFY: begin
                    // Matched or not, the received word becomes the new reference.
                    expected <= RX_TDATA + DATA_ONE;
                    if (match) begin
                        if (run_cnt == LOCK_LAST) begin
                            run_cnt <= '0;
                            state   <= qeciphy_rx_checker_pkg::LOCKED;
                            LOCKED  <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + RUN_ONE;
                        end
                    end else begin
                        run_cnt <= RUN_ONE;
                    end
                end
                qeciphy_rx_checker_pkg::LOCKED: begin
                    // Once locked the reference free-runs; corrupt data never re-seeds it.
                    expected <= expected + DATA_ONE;
                    if (match) begin
                        run_cnt <= '0;
                    end else if (run_cnt == LOSS_LAST) begin
                        run_cnt <= '0;
                        state   <= HUNT;
                        LOCKED  <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt + RUN_ONE;
                    end
                end
                default: begin
                    run_cnt <= '0;
                    state   <= HUNT;
                    LOCKED  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag; a clear coinciding with a mismatch keeps the new error.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            ERROR <= 1'b0;
        end else if (CLEAR) begin
            ERROR <= err_inc;
        end else if (err_inc) begin
            ERROR <= 1'b1;
        end
    end

    qeciphy_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_err_counter (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .clear     (CLEAR),
        .increment (err_inc),
        .count     (ERR_COUNT)
    );

    qeciphy_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_word_counter (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .clear     (CLEAR),
        .increment (word_inc),
        .count     (WORD_COUNT)
    );

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Self-checking bench for qeciphy_rx_checker: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_qeciphy_rx_checker;

    localparam int LOCK_T = 16;
    localparam int LOSS_T = 8;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b0;
    logic [63:0] RX_TDATA = '0;
    logic        RX_TVALID = 1'b0;
    logic        CLEAR = 1'b0;

    logic        RX_TREADY;
    logic        LOCKED;
    logic        ERROR;
    logic [31:0] ERR_COUNT;
    logic [31:0] WORD_COUNT;

    logic        RX_TREADY4;
    logic        LOCKED4;
    logic        ERROR4;
    logic [3:0]  ERR_COUNT4;
    logic [3:0]  WORD_COUNT4;

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    qeciphy_rx_checker dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .RX_TDATA   (RX_TDATA),
        .RX_TVALID  (RX_TVALID),
        .RX_TREADY  (RX_TREADY),
        .CLEAR      (CLEAR),
        .LOCKED     (LOCKED),
        .ERROR      (ERROR),
        .ERR_COUNT  (ERR_COUNT),
        .WORD_COUNT (WORD_COUNT)
    );

    qeciphy_rx_checker #(.CNT_WIDTH(4)) dut4 (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .RX_TDATA   (RX_TDATA),
        .RX_TVALID  (RX_TVALID),
        .RX_TREADY  (RX_TREADY4),
        .CLEAR      (CLEAR),
        .LOCKED     (LOCKED4),
        .ERROR      (ERROR4),
        .ERR_COUNT  (ERR_COUNT4),
        .WORD_COUNT (WORD_COUNT4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // locked: whether the checker should currently be locked
    // streak: length of the current run of consecutive +1 beats while unlocked
    // misses: consecutive mismatches seen while locked
    bit              m_ready  = 0;
    bit              m_synced = 0;
    bit              m_locked = 0;
    logic [63:0]     m_next   = '0;
    int              m_streak = 0;
    int              m_misses = 0;
    longint unsigned m_err    = 0;
    longint unsigned m_words  = 0;
    bit              m_error  = 0;

    function automatic logic [63:0] sat(input longint unsigned v, input int w);
        longint unsigned mx;
        mx = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            m_ready = 0; m_synced = 0; m_locked = 0; m_next = '0;
            m_streak = 0; m_misses = 0; m_err = 0; m_words = 0; m_error = 0;
        end else begin
            if (CLEAR) begin
                m_err = 0; m_words = 0; m_error = 0;
            end
            if (RX_TVALID && m_ready) begin
                if (m_locked) begin
                    m_words++;
                    if (RX_TDATA != m_next) begin
                        m_err++;
                        m_error = 1;
                        m_misses++;
                        if (m_misses == LOSS_T) begin
                            m_locked = 0;
                            m_synced = 0;
                        end
                    end else begin
                        m_misses = 0;
                    end
                    m_next = m_next + 64'd1;
                end else begin
                    if (m_synced && RX_TDATA == m_next) m_streak++;
                    else m_streak = 1;
                    m_synced = 1;
                    m_next = RX_TDATA + 64'd1;
                    if (m_streak == LOCK_T) begin
                        m_locked = 1;
                        m_misses = 0;
                    end
                end
            end
            m_ready = 1;
        end
    end

    // Per-cycle comparison of both DUT instances against the model.
    always @(negedge ACLK) begin
        if (!ARST) begin
            chk("ready",       RX_TREADY,   m_ready);
            chk("locked",      LOCKED,      m_locked);
            chk("error",       ERROR,       m_error);
            chk("err_count",   ERR_COUNT,   sat(m_err, 32));
            chk("word_count",  WORD_COUNT,  sat(m_words, 32));
            chk("locked4",     LOCKED4,     m_locked);
            chk("err_count4",  ERR_COUNT4,  sat(m_err, 4));
            chk("word_count4", WORD_COUNT4, sat(m_words, 4));
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] seq;

    task automatic drive(input logic v, input logic [63:0] d, input logic c);
        @(negedge ACLK);
        RX_TVALID = v;
        RX_TDATA  = d;
        CLEAR     = c;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0);
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, seq, 1'b0);
            seq = seq + 64'd1;
        end
    endtask

    // Asserts reset between edges and checks the outputs drop without a clock.
    task automatic do_reset();
        @(negedge ACLK);
        #2 ARST = 1'b1;
        RX_TVALID = 1'b0;
        CLEAR = 1'b0;
        #1;
        chk("async_ready",  RX_TREADY,  0);
        chk("async_locked", LOCKED,     0);
        chk("async_error",  ERROR,      0);
        chk("async_err",    ERR_COUNT,  0);
        chk("async_word",   WORD_COUNT, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARST = 1'b0;
    endtask

    initial begin
        int nbeats;
        int r;
        #1 ARST = 1'b1;
        do_reset();

        // Clean lock from 0
        seq = 64'd0;
        send_good(15);
        idle();
        chk("lock_after_15", LOCKED, 0);
        send_good(1);
        idle();
        chk("lock_after_16", LOCKED, 1);
        chk("words_at_lock", WORD_COUNT, 0);
        send_good(34);
        idle();
        chk("clean_words", WORD_COUNT, 34);
        chk("clean_err", ERR_COUNT, 0);
        chk("clean_error", ERROR, 0);

        // Wrap with random gaps
        do_reset();
        seq = 64'hFFFF_FFFF_FFFF_FFF0;
        nbeats = 0;
        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive(1'b1, seq, 1'b0);
                seq = seq + 64'd1;
                nbeats++;
            end else begin
                drive(1'b0, {$urandom, $urandom}, 1'b0);
            end
        end
        idle();
        chk("wrap_locked", LOCKED, 1);
        chk("wrap_err", ERR_COUNT, 0);
        chk("wrap_words", WORD_COUNT, 64'(nbeats - LOCK_T));

        // Single corruption
        drive(1'b0, 64'd0, 1'b1);
        drive(1'b1, 64'hDEAD, 1'b0);
        seq = seq + 64'd1;
        send_good(5);
        idle();
        chk("corrupt_err", ERR_COUNT, 1);
        chk("corrupt_error", ERROR, 1);
        chk("corrupt_locked", LOCKED, 1);
        chk("corrupt_words", WORD_COUNT, 6);

        // Twenty isolated errors saturate the 4-bit counter
        drive(1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, seq ^ 64'h1, 1'b0);
            seq = seq + 64'd1;
            send_good(1);
        end
        idle();
        chk("sat_err4", ERR_COUNT4, 15);
        chk("sat_err32", ERR_COUNT, 20);
        chk("sat_words4", WORD_COUNT4, 15);
        chk("sat_locked", LOCKED, 1);

        // Slip by +100: eight misses drop lock, then relock after 16 beats
        drive(1'b0, 64'd0, 1'b1);
        seq = seq + 64'd100;
        send_good(7);
        idle();
        chk("slip_still_locked", LOCKED, 1);
        send_good(1);
        idle();
        chk("slip_lost", LOCKED, 0);
        chk("slip_err", ERR_COUNT, 8);
        send_good(15);
        idle();
        chk("relock_15", LOCKED, 0);
        send_good(1);
        idle();
        chk("relock_16", LOCKED, 1);
        chk("relock_err_kept", ERR_COUNT, 8);
        chk("relock_error_kept", ERROR, 1);

        // CLEAR on the same edge as a mismatching locked beat
        send_good(3);
        drive(1'b1, seq ^ 64'hFF, 1'b1);
        seq = seq + 64'd1;
        idle();
        chk("clr_err", ERR_COUNT, 1);
        chk("clr_words", WORD_COUNT, 1);
        chk("clr_error", ERROR, 1);

        // Reset mid-VERIFY: relock takes a full sixteen beats
        do_reset();
        send_good(10);
        do_reset();
        send_good(15);
        idle();
        chk("rst_relock_15", LOCKED, 0);
        send_good(1);
        idle();
        chk("rst_relock_16", LOCKED, 1);

        // Randomized traffic
        seq = {$urandom, $urandom};
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                drive(1'b0, {$urandom, $urandom}, 1'b0);
            end else if (r < 15) begin
                drive(1'b1, seq ^ 64'(1 << $urandom_range(0, 31)), 1'b0);
                seq = seq + 64'd1;
            end else if (r < 17) begin
                seq = seq + 64'($urandom_range(2, 1000));
                send_good(1);
            end else if (r < 20) begin
                drive(1'b1, seq, 1'b1);
                seq = seq + 64'd1;
            end else if (r < 21) begin
                drive(1'b0, 64'd0, 1'b1);
            end else begin
                send_good(1);
            end
            if (i == 300) do_reset();
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
